// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } seq_div_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module seq_div_step #(
  parameter int N = 65
) (
  input  logic [N-1:0] r,
  input  logic         q_msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_next,
  output logic         q_bit
);

  logic [N:0] r_shift;
  logic [N:0] div_ext;

  // The extra top bit keeps the shifted remainder exact when the divisor
  // exceeds 2^(N-1); the difference always fits back into N bits.
  always_comb begin
    r_shift = {r, q_msb};
    div_ext = {1'b0, divisor};
    q_bit   = (r_shift >= div_ext);
    r_next  = q_bit ? N'(r_shift - div_ext) : r_shift[N-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with
// valid/ready ports on both sides. SEQ_DIV_DBZ_EN adds a fast divide-by-zero path and dbz flag.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int N = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem
`ifdef SEQ_DIV_DBZ_EN
  ,
  output logic         dbz
`endif
);

  localparam int            CW       = cnt_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  seq_div_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic [N-1:0]   div_q, div_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   q_shift;
  logic [N-1:0]   r_next;
  logic           q_bit;
`ifdef SEQ_DIV_DBZ_EN
  logic           dbz_q, dbz_d;
`endif

  seq_div_step #(
    .N(N)
  ) u_step (
    .r      (r_q),
    .q_msb  (q_q[N-1]),
    .divisor(div_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef SEQ_DIV_DBZ_EN
    dbz_d   = dbz_q;
`endif
    q_shift = {q_q[N-2:0], q_bit};

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          div_d   = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef SEQ_DIV_DBZ_EN
        // A zero divisor is resolved in the first busy cycle; q_q still holds the dividend.
        if (div_q == '0) begin
          state_d = DONE;
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
        end else begin
`endif
          q_d = q_shift;
          r_d = r_next;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            quot_d  = q_shift;
            rem_d   = r_next;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`ifdef SEQ_DIV_DBZ_EN
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef SEQ_DIV_DBZ_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
`ifdef SEQ_DIV_DBZ_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
`ifdef SEQ_DIV_DBZ_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  // Working registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    q_q   <= q_d;
    r_q   <= r_d;
    div_q <= div_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
`ifdef SEQ_DIV_DBZ_EN
  assign dbz       = dbz_q;
`endif

endmodule
